// File: rtl/fir_sum_pipe_pkg.sv
// Shared FIR definitions: tap count, default widths, adder-tree growth, round/scale/saturate.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fir_sum_pipe_pkg;

  localparam int NTAPS      = 4;
  localparam int FIR_PROD_W = 16;

  // Width of an exact sum of ntaps unsigned prod_w-bit values.
  function automatic int sum_w(input int prod_w, input int ntaps);
    return prod_w + $clog2(ntaps);
  endfunction

  // Optional round half-up, then right shift. 64-bit working width is wide enough
  // that the rounding increment can never overflow for any realistic sum width.
  function automatic logic [63:0] round_shift(input logic [63:0] s, input int shift,
                                              input bit rnd);
    logic [63:0] r;
    r = s;
    if (rnd && shift > 0) r = s + (64'd1 << (shift - 1));
    return r >> shift;
  endfunction

  // Largest value representable on an out_w-bit unsigned output.
  function automatic logic [63:0] sat_max(input int out_w);
    return (64'd1 << out_w) - 64'd1;
  endfunction

endpackage

// File: rtl/fir_sum_pipe_if.sv
// Product-set input and filtered-sample output bundle of the FIR summing pipeline.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs.
interface fir_sum_pipe_if #(
  parameter int PROD_W = 16,
  parameter int OUT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] p0;
  logic [PROD_W-1:0] p1;
  logic [PROD_W-1:0] p2;
  logic [PROD_W-1:0] p3;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              sat;
  logic              sat_clr;

  modport master (
    output in_valid, p0, p1, p2, p3, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, sat
  );

  modport slave (
    input  in_valid, p0, p1, p2, p3, out_ready, sat_clr,
    output in_ready, out_valid, out_data, sat
  );
endinterface

// File: rtl/fir_round_sat.sv
// Rounds, scales and saturates a full-precision adder-tree sum to the output width.
// Latency: combinational.
// Backpressure: none (pure function of the input).
module fir_round_sat
  import fir_sum_pipe_pkg::*;
#(
  parameter int SUM_W = 18,
  parameter int OUT_W = 16,
  parameter int SHIFT = 2,
  parameter int ROUND = 1
) (
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] res,
  output logic             sat
);

  logic [63:0] q;

  // Scale then clamp to the largest output code; sat flags the clamp.
  always_comb begin
    q   = round_shift(64'(sum), SHIFT, ROUND != 0);
    sat = (q > sat_max(OUT_W));
    res = sat ? OUT_W'(sat_max(OUT_W)) : q[OUT_W-1:0];
  end

endmodule

// File: rtl/fir_sum_pipe.sv
// Sums four tap products in a two-level adder tree, then rounds/scales/saturates.
// Latency: 3 cycles accepted input to out_valid; throughput 1 per cycle.
// Backpressure: one global enable freezes all stages while out_valid && !out_ready.
module fir_sum_pipe
  import fir_sum_pipe_pkg::*;
#(
  parameter int PROD_W = FIR_PROD_W,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 2,
  parameter int ROUND  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_sum_pipe_if.slave  bus
);

  localparam int SUM_W = sum_w(PROD_W, NTAPS);

  logic              en;
  logic              v1;
  logic              v2;
  logic [PROD_W:0]   s1a;
  logic [PROD_W:0]   s1b;
  logic [SUM_W-1:0]  s2;
  logic [OUT_W-1:0]  rs_dat;
  logic              rs_sat;

  // A stage may advance whenever the output slot is empty or being drained.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  fir_round_sat #(
    .SUM_W (SUM_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .ROUND (ROUND)
  ) u_round_sat (
    .sum (s2),
    .res (rs_dat),
    .sat (rs_sat)
  );

  // Valid bits track occupancy; bubbles travel as v=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (en) begin
      v1            <= bus.in_valid;
      v2            <= v1;
      bus.out_valid <= v2;
    end
  end

  // Adder-tree data needs no reset: it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      s1a <= (PROD_W+1)'(bus.p0) + (PROD_W+1)'(bus.p1);
      s1b <= (PROD_W+1)'(bus.p2) + (PROD_W+1)'(bus.p3);
      s2  <= SUM_W'(s1a) + SUM_W'(s1b);
    end
  end

  // Output register is reset so the port reads zero after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
    end else if (en) begin
      bus.out_data <= rs_dat;
    end
  end

  // Sticky saturation flag; a new saturating load beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sat <= 1'b0;
    end else if (en && v2 && rs_sat) begin
      bus.sat <= 1'b1;
    end else if (bus.sat_clr) begin
      bus.sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_sum_pipe.sv
// Drives three parameterisations of the summing pipeline with shared stimulus.
// Latency: n/a (testbench).
// Backpressure: out_ready driven by directed patterns and randomly.
module tb_fir_sum_pipe;

  localparam int SH [3] = '{2, 2, 0};
  localparam int RN [3] = '{1, 0, 1};
  localparam int OW [3] = '{16, 16, 11};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] p [4];
  bit          mon_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Expected results per DUT: bits 15:0 value, bit 16 saturated, bit 17 already credited to sat.
  int unsigned exp_q [3][$];
  bit          sat_exp [3];
  int          n_pop [3];

  always #5 clk = ~clk;

  fir_sum_pipe_if #(.PROD_W(16), .OUT_W(16)) ia ();
  fir_sum_pipe_if #(.PROD_W(16), .OUT_W(16)) ib ();
  fir_sum_pipe_if #(.PROD_W(16), .OUT_W(11)) ic ();

  assign ia.in_valid = iv;  assign ib.in_valid = iv;  assign ic.in_valid = iv;
  assign ia.out_ready = ordy; assign ib.out_ready = ordy; assign ic.out_ready = ordy;
  assign ia.sat_clr = clr;  assign ib.sat_clr = clr;  assign ic.sat_clr = clr;
  assign ia.p0 = p[0]; assign ia.p1 = p[1]; assign ia.p2 = p[2]; assign ia.p3 = p[3];
  assign ib.p0 = p[0]; assign ib.p1 = p[1]; assign ib.p2 = p[2]; assign ib.p3 = p[3];
  assign ic.p0 = p[0]; assign ic.p1 = p[1]; assign ic.p2 = p[2]; assign ic.p3 = p[3];

  fir_sum_pipe #(.PROD_W(16), .OUT_W(16), .SHIFT(2), .ROUND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  fir_sum_pipe #(.PROD_W(16), .OUT_W(16), .SHIFT(2), .ROUND(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));
  fir_sum_pipe #(.PROD_W(16), .OUT_W(11), .SHIFT(0), .ROUND(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave));

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact sum, optional half-up rounding, shift, clamp.
  function automatic int unsigned ref_item(input int sum, input int d);
    int r, q, mx;
    r  = sum + ((RN[d] != 0 && SH[d] > 0) ? (1 << (SH[d] - 1)) : 0);
    q  = r >> SH[d];
    mx = (1 << OW[d]) - 1;
    if (q > mx) return 32'(mx) | (32'd1 << 16);
    return 32'(q);
  endfunction

  // Scoreboard step, evaluated on the falling edge for the upcoming rising edge.
  task automatic mon(input int d, input int ov, input int od, input int ir, input int st);
    int unsigned h;
    chk($sformatf("in_ready_%0d", d), ir, int'(ov == 0 || ordy));
    if (ov != 0) begin
      if (exp_q[d].size() == 0) begin
        chk($sformatf("spurious_out_%0d", d), ov, 0);
      end else begin
        h = exp_q[d][0];
        if (!h[17]) begin
          sat_exp[d] = sat_exp[d] | h[16];
          exp_q[d][0] = h | (32'd1 << 17);
        end
      end
    end
    chk($sformatf("sat_%0d", d), st, int'(sat_exp[d]));
    if (ov != 0 && ordy && exp_q[d].size() > 0) begin
      h = exp_q[d].pop_front();
      n_pop[d]++;
      chk($sformatf("data_%0d", d), od, int'(h[15:0]));
    end
    if (iv && ir != 0)
      exp_q[d].push_back(ref_item(int'(p[0]) + int'(p[1]) + int'(p[2]) + int'(p[3]), d));
    if (clr) sat_exp[d] = 1'b0;
  endtask

  // Per-cycle scoreboard for all three instances.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      mon(0, int'(ia.out_valid), int'(ia.out_data), int'(ia.in_ready), int'(ia.sat));
      mon(1, int'(ib.out_valid), int'(ib.out_data), int'(ib.in_ready), int'(ib.sat));
      mon(2, int'(ic.out_valid), int'(ic.out_data), int'(ic.in_ready), int'(ic.sat));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int a, input int b, input int c, input int d);
    p[0] = 16'(a); p[1] = 16'(b); p[2] = 16'(c); p[3] = 16'(d);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    set_p(a, b, c, d);
    iv = 1'b1;
    cyc();
    iv = 1'b0;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      sat_exp[d] = 1'b0;
    end
  endtask

  initial begin
    int lat, k, c, acc, pops0;
    bit h [16];
    set_p(0, 0, 0, 0);
    model_clear();
    for (int d = 0; d < 3; d++) n_pop[d] = 0;

    // Reset state
    #12;
    chk("rst_out_valid", int'(ia.out_valid), 0);
    chk("rst_out_data", int'(ia.out_data), 0);
    chk("rst_sat", int'(ic.sat), 0);
    chk("rst_in_ready", int'(ia.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ordy  = 1'b1;
    mon_en = 1'b1;
    cyc();

    // Basic sum and 3-cycle latency
    send(2040, 2040, 2040, 2040);
    lat = 1;
    while (!ia.out_valid && lat < 10) begin
      cyc();
      lat++;
    end
    chk("latency", lat, 3);
    chk("t1_a_data", int'(ia.out_data), 2040);
    chk("t1_a_sat", int'(ia.sat), 0);
    chk("t1_c_data", int'(ic.out_data), 2047);
    chk("t1_c_sat", int'(ic.sat), 1);

    // Rounding versus truncation
    send(2040, 2040, 2040, 2042);
    cyc(); cyc();
    chk("t2_round", int'(ia.out_data), 2041);
    chk("t2_trunc", int'(ib.out_data), 2040);
    cyc();

    // Sticky clear, then clear colliding with a new saturation
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t3_cleared", int'(ic.sat), 0);
    clr = 1'b1;
    send(2040, 2040, 2040, 2040);
    cyc();
    chk("t3_clr_hold", int'(ic.sat), 0);
    cyc();
    chk("t3_set_wins", int'(ic.sat), 1);
    clr = 1'b0;
    cyc(); cyc();

    // Streaming with a stall window
    pops0 = n_pop[2];
    k = 1; c = 0;
    while (k <= 10 && c < 100) begin
      c++;
      ordy = !(c >= 4 && c <= 8);
      set_p(k, 0, 0, 0);
      iv = 1'b1;
      #1;
      acc = int'(ia.in_ready);
      if (!ordy && ia.out_valid) chk("t4_stall_rdy", int'(ia.in_ready), 0);
      @(posedge clk); #1;
      if (acc != 0) k++;
    end
    iv = 1'b0;
    ordy = 1'b1;
    repeat (8) cyc();
    chk("t4_count", n_pop[2] - pops0, 10);
    chk("t4_drained", exp_q[2].size(), 0);

    // Alternating bubbles; bubble data would saturate if it leaked
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      h[i] = (i < 12) && (i % 2 == 0);
      iv = h[i];
      if (h[i]) set_p($urandom_range(0, 511), $urandom_range(0, 511),
                      $urandom_range(0, 511), $urandom_range(0, 511));
      else      set_p(16'hffff, 16'hffff, 16'hffff, 16'hffff);
      cyc();
      if (i >= 2) chk("t5_valid_lag", int'(ia.out_valid), int'(h[i-2]));
    end
    chk("t5_no_sat", int'(ic.sat), 0);

    // Random traffic and back-pressure
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < 4; j++)
        p[j] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 600));
      cyc();
    end
    iv = 1'b0; ordy = 1'b1; clr = 1'b0;
    repeat (8) cyc();
    for (int d = 0; d < 3; d++) chk($sformatf("rand_drained_%0d", d), exp_q[d].size(), 0);

    // Reset while results are in flight
    set_p(100, 200, 300, 400);
    iv = 1'b1;
    repeat (4) cyc();
    chk("t6_pre_valid", int'(ia.out_valid), 1);
    #2;
    rst_n = 1'b0;
    iv = 1'b0;
    #1;
    chk("t6_valid_a", int'(ia.out_valid), 0);
    chk("t6_data_a", int'(ia.out_data), 0);
    chk("t6_valid_c", int'(ic.out_valid), 0);
    chk("t6_data_c", int'(ic.out_data), 0);
    model_clear();
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t6_no_stale", int'(ia.out_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
